serial_code_display: RTL

- Parametrised serial code-tree decoder with a multi-digit 7-segment display buffer.
- Bits arrive one per strobe, MSB-first. An end-of-symbol strobe commits the accumulated code.
- The committed code is decoded to a 7-segment glyph and shifted into a DIGITS-wide display register.
- Sits between the front-end that samples the key/button line and the board's multiplexed 7-segment driver.

---
 rtl/serial_code_pkg.sv | 65 ++++++
 rtl/serial_code_display_code_to_seg.sv | 44 ++++
 rtl/serial_code_display.sv | 110 +++++++++++
 3 files changed

// File: rtl/serial_code_pkg.sv
// Shared types and constants for the serial code-tree decoder: FSM states,
// 7-segment glyphs in g,f,e,d,c,b,a order, and the code-tree lookup table.
package serial_code_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_OVF     = 2'd2
  } state_e;

  // Segment bit positions inside one 7-bit digit; 1 = segment lit.
  localparam int SEG_BIT_A = 0;
  localparam int SEG_BIT_B = 1;
  localparam int SEG_BIT_C = 2;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 4;
  localparam int SEG_BIT_F = 5;
  localparam int SEG_BIT_G = 6;

  function automatic logic [6:0] seg7(input logic a, input logic b, input logic c,
                                      input logic d, input logic e, input logic f,
                                      input logic g);
    logic [6:0] s;
    s            = '0;
    s[SEG_BIT_A] = a;
    s[SEG_BIT_B] = b;
    s[SEG_BIT_C] = c;
    s[SEG_BIT_D] = d;
    s[SEG_BIT_E] = e;
    s[SEG_BIT_F] = f;
    s[SEG_BIT_G] = g;
    return s;
  endfunction

  //                                     a     b     c     d     e     f     g
  localparam logic [6:0] SEG_BLANK = seg7(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  localparam logic [6:0] SEG_ERR   = seg7(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  localparam logic [6:0] SEG_A     = seg7(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
  localparam logic [6:0] SEG_B     = seg7(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
  localparam logic [6:0] SEG_C     = seg7(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
  localparam logic [6:0] SEG_D     = seg7(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
  localparam logic [6:0] SEG_E     = seg7(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
  localparam logic [6:0] SEG_F     = seg7(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  localparam logic [6:0] SEG_US    = seg7(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

  // One leaf of the code tree: code is right-aligned, first received bit is its MSB.
  typedef struct packed {
    logic [2:0] len;
    logic [3:0] code;
    logic [6:0] glyph;
  } tree_entry_t;

  localparam int TREE_ENTRIES = 7;

  localparam tree_entry_t TREE_TABLE [TREE_ENTRIES] = '{
    '{len: 3'd2, code: 4'b0000, glyph: SEG_A},
    '{len: 3'd2, code: 4'b0001, glyph: SEG_B},
    '{len: 3'd3, code: 4'b0100, glyph: SEG_C},
    '{len: 3'd3, code: 4'b0101, glyph: SEG_D},
    '{len: 3'd3, code: 4'b0110, glyph: SEG_E},
    '{len: 3'd4, code: 4'b1110, glyph: SEG_F},
    '{len: 3'd4, code: 4'b1111, glyph: SEG_US}
  };

endpackage

// File: rtl/serial_code_display_code_to_seg.sv
// Combinational code-tree lookup: maps an accumulated (len, code) symbol to a
// 7-segment glyph, flagging overflowed or unknown symbols as invalid.
module code_to_seg
  import serial_code_pkg::*;
#(
  parameter  int MAX_LEN = 4,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic [LW-1:0]      len_i,
  input  logic [MAX_LEN-1:0] code_i,
  input  logic               ovf_i,
  output logic [6:0]         glyph_o,
  output logic               invalid_o
);

  // Wide enough for both the accumulator and the 4-bit table codes.
  localparam int CW = (MAX_LEN > 4) ? MAX_LEN : 4;

  logic [CW-1:0] code_w;
  logic [31:0]   len_w;

  assign code_w = CW'(code_i);
  assign len_w  = 32'(len_i);

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    glyph_o   = SEG_ERR;
    invalid_o = 1'b1;
    if (!ovf_i) begin
      if (len_w == 32'd0) begin
        glyph_o   = SEG_BLANK;
        invalid_o = 1'b0;
      end else begin
        for (int k = 0; k < TREE_ENTRIES; k++) begin
          if (len_w == 32'(TREE_TABLE[k].len) && code_w == CW'(TREE_TABLE[k].code)) begin
            glyph_o   = TREE_TABLE[k].glyph;
            invalid_o = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/serial_code_display.sv
// Serial MSB-first code-tree decoder feeding a DIGITS-wide 7-segment display
// shift register; newest digit sits in Q[6:0].
module serial_code_display
  import serial_code_pkg::*;
#(
  parameter int MAX_LEN = 4,
  parameter int DIGITS  = 4
) (
  input  logic                  Clk,
  input  logic                  Resetn,
  input  logic                  Valid,
  input  logic                  I,
  input  logic                  Eos,
  output logic [7*DIGITS-1:0]   Q,
  output logic                  Done,
  output logic                  Err
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int QW = 7 * DIGITS;

  state_e               state_q, state_d;
  logic [LW-1:0]        len_q, len_d;
  logic [MAX_LEN-1:0]   code_q, code_d;
  logic [QW-1:0]        q_q, q_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  // Symbol after applying this edge's bit, if any; this is what Eos commits.
  state_e               acc_state;
  logic [LW-1:0]        acc_len;
  logic [MAX_LEN-1:0]   acc_code;

  logic [6:0]           glyph;
  logic                 invalid;

  always_comb begin
    acc_state = state_q;
    acc_len   = len_q;
    acc_code  = code_q;
    if (Valid) begin
      unique case (state_q)
        ST_IDLE, ST_COLLECT: begin
          if (len_q < LW'(MAX_LEN)) begin
            acc_code  = MAX_LEN'({code_q, I});
            acc_len   = len_q + LW'(1);
            acc_state = ST_COLLECT;
          end else begin
            acc_state = ST_OVF;
          end
        end
        default: acc_state = ST_OVF;
      endcase
    end
  end

  code_to_seg #(
    .MAX_LEN (MAX_LEN)
  ) u_code_to_seg (
    .len_i     (acc_len),
    .code_i    (acc_code),
    .ovf_i     (acc_state == ST_OVF),
    .glyph_o   (glyph),
    .invalid_o (invalid)
  );

  always_comb begin
    state_d = acc_state;
    len_d   = acc_len;
    code_d  = acc_code;
    q_d     = q_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (Eos) begin
      // Shifting by a whole digit also covers DIGITS == 1 without a negative slice.
      q_d     = (q_q << 7) | QW'(glyph);
      done_d  = 1'b1;
      err_d   = invalid;
      state_d = ST_IDLE;
      len_d   = '0;
      code_d  = '0;
    end
  end

  // NOTE: the display register is only DIGITS*7 flops, so it is reset like any
  // other state to guarantee a blank display after power-up.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      code_q  <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      len_q   <= len_d;
      code_q  <= code_d;
      q_q     <= q_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Q    = q_q;
  assign Done = done_q;
  assign Err  = err_q;

endmodule
